// File: rtl/ifetch_mem_responder.sv
// Instruction-fetch responder: one 16B-aligned block per request, fetched as sequential beats
// over a single-outstanding memory read port. Define IFR_LINEBUF_EN to add a one-line buffer.
module ifetch_mem_responder #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned BEAT_W = 64
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              pc_index_valid_i,
  input  logic [ADDR_W-1:0] pc_index_i,
  output logic              pc_index_ready_o,
  output logic              pc_operation_done_o,
  output logic [DATA_W-1:0] pc_read_inst_o,
  input  logic              flush_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_resp_valid_i,
  input  logic [BEAT_W-1:0] mem_resp_data_i,
  input  logic              linebuf_inval_i
);

  localparam int unsigned Beats = DATA_W / BEAT_W;
  localparam int unsigned BeatIdxW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [ADDR_W-1:0] BeatBytes = ADDR_W'(BEAT_W / 8);
  localparam logic [BeatIdxW-1:0] LastBeat = BeatIdxW'(Beats - 1);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StDone} state_e;

  state_e              state_q;
  logic [BeatIdxW-1:0] beat_q;
  logic [ADDR_W-1:0]   base_q;
  logic [DATA_W-1:0]   data_q;

  logic              accept;
  logic              lb_hit;
  logic [ADDR_W-1:0] req_base;

  assign req_base = {pc_index_i[ADDR_W-1:4], 4'h0};
  assign accept   = pc_index_valid_i & pc_index_ready_o;

  // Ready is gated by reset so it reads 0 while the block is held in reset.
  assign pc_index_ready_o    = reset_ni & (state_q == StIdle) & ~flush_i;
  assign mem_req_valid_o     = (state_q == StReq);
  assign mem_req_addr_o      = base_q + ADDR_W'(beat_q) * BeatBytes;
  assign pc_operation_done_o = (state_q == StDone) & ~flush_i;
  assign pc_read_inst_o      = data_q;

`ifdef IFR_LINEBUF_EN
  logic              lb_valid_q;
  logic [ADDR_W-5:0] lb_tag_q;
  logic              unused_bits;

  // An invalidate in the accept cycle forces a miss.
  assign lb_hit = lb_valid_q & ~linebuf_inval_i & (lb_tag_q == pc_index_i[ADDR_W-1:4]);
  assign unused_bits = ^pc_index_i[3:0];

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      lb_valid_q <= 1'b0;
      lb_tag_q   <= '0;
    end else if (linebuf_inval_i || (accept && !lb_hit)) begin
      lb_valid_q <= 1'b0;
    end else if (state_q == StDone && !flush_i) begin
      lb_valid_q <= 1'b1;
      lb_tag_q   <= base_q[ADDR_W-1:4];
    end
  end
`else
  logic unused_bits;

  assign lb_hit = 1'b0;
  assign unused_bits = ^{pc_index_i[3:0], linebuf_inval_i};
`endif

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      beat_q  <= '0;
      base_q  <= '0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            base_q  <= req_base;
            beat_q  <= '0;
            state_q <= lb_hit ? StDone : StReq;
          end
        end
        StReq: begin
          if (mem_req_ready_i) begin
            state_q <= flush_i ? StDrain : StWait;
          end else if (flush_i) begin
            state_q <= StIdle;
          end
        end
        StWait: begin
          // A response arriving with the flush is itself the one to discard.
          if (mem_resp_valid_i) begin
            if (flush_i) begin
              state_q <= StIdle;
            end else begin
              data_q[beat_q*BEAT_W +: BEAT_W] <= mem_resp_data_i;
              if (beat_q == LastBeat) begin
                state_q <= StDone;
              end else begin
                beat_q  <= beat_q + BeatIdxW'(1);
                state_q <= StReq;
              end
            end
          end else if (flush_i) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (mem_resp_valid_i) begin
            state_q <= StIdle;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
